// File: rtl/pc_pkg.sv
// Shared types and elaboration-time parameter checks for the fetch PC generator.
// Imported by pc_unit and pc_ras.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_RAS,
        SEL_REDIR,
        SEL_TRAP
    } next_pc_sel_t;

    function automatic bit is_pow2(input longint unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // True when the INC, RESET_VECTOR and RAS_DEPTH combination is usable.
    function automatic bit params_ok(
        input int unsigned xlen,
        input logic [63:0] reset_vector,
        input int unsigned inc,
        input int unsigned ras_depth
    );
        bit ok;
        ok = (xlen >= 2);
        ok = ok && is_pow2(longint'(inc));
        ok = ok && ((reset_vector & (64'(inc) - 64'd1)) == 64'd0);
        ok = ok && (ras_depth >= 2) && is_pow2(longint'(ras_depth));
        return ok;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top and flush.
// When full, a push silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   wr_idx;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            wr_en;
    logic            do_push;
    logic            do_pop;
    logic            do_replace;

    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign top     = mem[top_idx];

    // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
    always_comb begin
        do_replace = push & pop & ~empty;
        do_push    = push & ~do_replace;
        do_pop     = pop & ~push & ~empty;

        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;

        if (flush) begin
            ptr_nxt   = '0;
            count_nxt = '0;
        end else if (do_replace) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (do_push) begin
            wr_en   = 1'b1;
            wr_idx  = ptr;
            ptr_nxt = ptr + PW'(1);
            if (count != FULL) begin
                count_nxt = count + CW'(1);
            end
        end else if (do_pop) begin
            ptr_nxt   = top_idx;
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end

    // Entry storage carries no reset; it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter generator with valid/ready handshake, prioritised
// trap/redirect loading and a return-address stack for call/return prediction.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          INC          = 4,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_V - XLEN'(1));

    if (!params_ok(XLEN, 64'(RESET_VECTOR), INC, RAS_DEPTH)) begin : g_bad_params
        $error("pc_unit: INC/RAS_DEPTH must be powers of two, RAS_DEPTH >= 2, RESET_VECTOR INC-aligned");
    end

    next_pc_sel_t    sel;
    logic            fire;
    logic            ctl_override;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] pc_nxt;

    assign fire         = pc_valid & pc_ready & ~stall;
    assign ctl_override = trap_valid | redirect_valid;
    assign pc_seq       = pc + INC_V;

    // Predecode hints only touch the RAS on an accepted fetch that is not being thrown away.
    assign ras_push = fire & ~ctl_override & call_push;
    assign ras_pop  = fire & ~ctl_override & ret_pop;

    always_comb begin
        sel = SEL_HOLD;
        if (trap_valid) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (fire && ret_pop && !ras_empty) begin
            sel = SEL_RAS;
        end else if (fire) begin
            sel = SEL_SEQ;
        end
    end

    always_comb begin
        pc_nxt = pc;
        unique case (sel)
            SEL_TRAP:  pc_nxt = trap_pc & ALIGN_MASK;
            SEL_REDIR: pc_nxt = redirect_pc & ALIGN_MASK;
            SEL_RAS:   pc_nxt = ras_top;
            SEL_SEQ:   pc_nxt = pc_seq;
            SEL_HOLD:  pc_nxt = pc;
            default:   pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            pc_valid <= 1'b1;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .flush (trap_valid),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (pc_seq),
        .top   (ras_top),
        .empty (ras_empty)
    );

endmodule
